// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared constants for the EX-stage multiply/divide sequencer:
//                RV32M funct3 encodings, FSM state encodings, latency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Default datapath width and the full-length latency that goes with it
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 3;

  // Full-length latency for an arbitrary width
  function automatic int muldiv_lat(input int width);
    return width + 3;
  endfunction

  // rs1 is interpreted as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as signed for MUL, MULH, DIV, REM
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration on the {acc, q} register pair.
//                Multiply: conditional add of m, then shift right by one.
//                Divide  : shift left by one, trial-subtract m, restore on
//                          borrow, shift the quotient bit into q.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  // Single shift-add or restoring-subtract step
  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, m_i};
    shifted = {acc_i, q_i[WIDTH-1]};
    acc_o   = acc_i;
    q_o     = q_i;
    if (!is_div_i) begin
      // The carry out of the add becomes the new MSB of acc
      if (q_i[0]) begin
        {acc_o, q_o} = {sum, q_i[WIDTH-1:1]};
      end else begin
        {acc_o, q_o} = {1'b0, acc_i, q_i[WIDTH-1:1]};
      end
    end else begin
      // Partial remainder stays below m, so it always fits back in WIDTH bits
      if (shifted >= {1'b0, m_i}) begin
        acc_o = WIDTH'(shifted - {1'b0, m_i});
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq
//  Description : Multi-cycle RV32M multiply/divide sequencer for the EX stage.
//                IDLE -> PREP -> CALC (WIDTH steps) -> FIX -> DONE, with a
//                PREP -> DONE short path for divide-by-zero and overflow.
//                Optional macro MULDIV_EARLY_OUT_EN also takes the short
//                path for zero multiplies and divides with |a| < |b|.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_seq
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int              CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, q_q, m_q;
  logic [WIDTH-1:0] acc_d, q_d;
  logic [CW-1:0]    cnt_q;
  logic             sign_a_q, sign_b_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             is_div;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             short_path;
  logic [WIDTH-1:0] short_res;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, fix_res;

  assign is_div = op_q[2];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .m_i      (m_q),
    .acc_o    (acc_d),
    .q_o      (q_d)
  );

  // Sign flags and operand magnitudes from the captured operands
  always_comb begin
    sign_a = op_signed_a(op_q) & a_q[WIDTH-1];
    sign_b = op_signed_b(op_q) & b_q[WIDTH-1];
    mag_a  = sign_a ? -a_q : a_q;
    mag_b  = sign_b ? -b_q : b_q;
  end

  // Operations that can be answered directly from PREP
  always_comb begin
    short_path = 1'b0;
    short_res  = '0;
    if (is_div && (b_q == '0)) begin
      short_path = 1'b1;
      short_res  = op_q[1] ? a_q : '1;
    end else if (is_div && !op_q[0] && (a_q == MIN_VAL) && (b_q == '1)) begin
      short_path = 1'b1;
      short_res  = op_q[1] ? '0 : MIN_VAL;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div && ((a_q == '0) || (b_q == '0))) begin
      short_path = 1'b1;
      short_res  = '0;
    end else if (is_div && (mag_a < mag_b)) begin
      short_path = 1'b1;
      short_res  = op_q[1] ? a_q : '0;
    end
`endif
  end

  // Sign correction and result selection applied in FIX
  always_comb begin
    prod     = {acc_q, q_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
    rem_fix  = sign_a_q ? -acc_q : acc_q;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // Sequencer FSM, step counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q    <= op_i;
            a_q     <= a_i;
            b_q     <= b_i;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          sign_a_q <= sign_a;
          sign_b_q <= sign_b;
          cnt_q    <= '0;
          acc_q    <= '0;
          // Divide shifts the dividend through q; multiply shifts the multiplier
          q_q      <= is_div ? mag_a : mag_b;
          m_q      <= is_div ? mag_b : mag_a;
          if (short_path) begin
            result_q <= short_res;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
  assign stall_o  = (start_i && (state_q == S_IDLE)) || busy_o;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_seq
//  Description : Scoreboard bench for ex_muldiv_seq (WIDTH=32). The driver
//                pushes expected results computed with plain 64-bit
//                arithmetic; a monitor pops and compares on every done pulse
//                and checks busy against the expected occupancy windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_seq;

  localparam int          W    = 32;
  localparam int          LATF = W + 3;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;

  ex_muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  op;
  } exp_t;

  exp_t sb[$];
  int   win_lo[$];
  int   win_hi[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sbv = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [63:0]     p;
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        return 32'(sa / sbv);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sbv);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  // Reference start-to-done latency
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
`ifdef MULDIV_EARLY_OUT_EN
    longint unsigned ma, mb;
`endif
    sgn = (op == 3'd4) || (op == 3'd6);
    if (op[2]) begin
      if (b == 0) return 2;
      if (sgn && a == MINV && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
      ma = (sgn && a[31]) ? 64'(-longint'($signed(a))) : 64'(a);
      mb = (sgn && b[31]) ? 64'(-longint'($signed(b))) : 64'(b);
      if (ma < mb) return 2;
`endif
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (a == 0 || b == 0) return 2;
`endif
    return LATF;
  endfunction

  // Record the expected result and busy window for an op accepted from cycle k
  task automatic expect_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    int lat;
    lat = ref_lat(op, a, b);
    sb.push_back(exp_t'{ref_result(op, a, b), k + lat, op});
    win_lo.push_back(k + 1);
    win_hi.push_back(k + lat - 1);
  endtask

  // Bounded wait until every expected result has been observed
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d results still pending at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
  endtask

  // Issue one op in IDLE, scramble the inputs after accept, wait for done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    expect_op(op, a, b, cyc);
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i    = 3'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    drain(LATF + 8);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return MINV;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: busy against expected windows, results popped on done
  always @(negedge clk) begin
    logic eb;
    exp_t e;
    if (mon_en && !rst) begin
      eb = 1'b0;
      for (int i = 0; i < win_lo.size(); i++)
        if (cyc >= win_lo[i] && cyc <= win_hi[i]) eb = 1'b1;
      check32("busy", {31'b0, busy_o}, {31'b0, eb});
      if (done_o) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done: unexpected pulse at cycle %0d, result %h", cyc, result_o);
        end else begin
          e = sb.pop_front();
          check32($sformatf("result op%0d", e.op), result_o, e.res);
          check32($sformatf("done cycle op%0d", e.op), cyc, e.due);
        end
      end
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, lat1;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check32("reset result", result_o, 32'h0);
    check32("reset done", {31'b0, done_o}, 32'h0);
    check32("reset stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;

    // MUL 7 * -3 with stall profile across the whole op
    k = cyc;
    op_i = 3'd0; a_i = 32'd7; b_i = 32'hFFFF_FFFD; start_i = 1'b1;
    expect_op(3'd0, 32'd7, 32'hFFFF_FFFD, k);
    for (int i = 0; i <= LATF; i++) begin
      @(negedge clk);
      check32($sformatf("stall c%0d", i), {31'b0, stall_o}, {31'b0, (i <= LATF - 1)});
      if (i == 0) begin
        @(posedge clk); #1;
        start_i = 1'b0; a_i = $urandom; b_i = $urandom;
      end
    end
    @(posedge clk); #1;
    drain(8);

    // Signed divide / remainder with negative dividend
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    // Divide by zero
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h1234_5678, 32'd0);
    run_op(3'd6, 32'h8765_4321, 32'd0);
    // Signed overflow
    run_op(3'd4, MINV, 32'hFFFF_FFFF);
    run_op(3'd6, MINV, 32'hFFFF_FFFF);
    // High-half products of all ones
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Zero operands and small dividends
    run_op(3'd0, 32'h0, 32'h1234_5678);
    run_op(3'd5, 32'd3, 32'd10);
    run_op(3'd6, 32'hFFFF_FFFD, 32'd10);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] ra, rb;
      o  = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(o, ra, rb);
    end

    // Flush in the middle of a MUL: idle next cycle, no done
    k = cyc;
    op_i = 3'd0; a_i = 32'd9; b_i = 32'd11; start_i = 1'b1;
    win_lo.push_back(k + 1);
    win_hi.push_back(k + 10);
    @(posedge clk); #1;
    start_i = 1'b0;
    while (cyc < k + 10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    repeat (LATF + 3) @(posedge clk);
    #1;

    // Flush and start together in IDLE: nothing accepted
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd3; a_i = 32'd4; b_i = 32'd4;
    @(negedge clk);
    check32("stall start+flush", {31'b0, stall_o}, 32'h1);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    repeat (LATF + 3) @(posedge clk);
    #1;

    // Start held high: second op accepted only in IDLE, with inputs present then
    k = cyc;
    op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    lat1 = ref_lat(3'd5, 32'd100, 32'd7);
    expect_op(3'd5, 32'd100, 32'd7, k);
    @(posedge clk); #1;
    op_i = 3'd3; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0;
    k2 = k + lat1 + 1;
    expect_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, k2);
    while (cyc < k2 + 1) begin @(posedge clk); #1; end
    start_i = 1'b0;
    drain(2 * LATF + 8);

    // Reset in the middle of an op
    k = cyc;
    op_i = 3'd1; a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D; start_i = 1'b1;
    win_lo.push_back(k + 1);
    win_hi.push_back(k + 5);
    @(posedge clk); #1;
    start_i = 1'b0;
    while (cyc < k + 5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("result after reset", result_o, 32'h0);
    check32("done after reset", {31'b0, done_o}, 32'h0);
    repeat (LATF + 3) @(posedge clk);
    #1;

    // Normal operation resumes after reset
    run_op(3'd0, 32'd3, 32'd5);
    run_op(3'd7, 32'd17, 32'd5);

    repeat (5) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL leftover: %0d expected results never seen", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
